// File: rtl/input_conditioner_8.sv
// input_conditioner_8
// Eight independent channels, each with a 2-flop synchroniser, a debounce
// counter, a debounced level register and one-cycle rise/fall pulses.
// Every output comes straight from a flop, so no combinational path exists
// from raw to any output.
module input_conditioner_8 #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] raw,
  output logic [7:0] stable,
  output logic [7:0] rise,
  output logic [7:0] fall
);

  // Terminal count: the last mismatching sample before the level is accepted.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [7:0]                sync1_q, sync1_d;
  logic [7:0]                sync2_q, sync2_d;
  logic [7:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]                stable_q, stable_d;
  logic [7:0]                rise_q, rise_d;
  logic [7:0]                fall_q, fall_d;

  // Next-state logic: synchroniser shift plus per-channel debounce decision.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (sync2_q[i[2:0]] == stable_q[i[2:0]]) begin
        // Any matching sample discards a count in progress.
        cnt_d[i[2:0]] = '0;
      end else if (cnt_q[i[2:0]] == CNT_LAST) begin
        // Qualified: flip the level and emit the matching pulse together.
        stable_d[i[2:0]] = sync2_q[i[2:0]];
        cnt_d[i[2:0]]    = '0;
        rise_d[i[2:0]]   = sync2_q[i[2:0]];
        fall_d[i[2:0]]   = ~sync2_q[i[2:0]];
      end else begin
        cnt_d[i[2:0]] = cnt_q[i[2:0]] + CNT_WIDTH'(1);
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: tb/tb_input_conditioner_8.sv
// Bench for input_conditioner_8 with DEBOUNCE_CYCLES = 4. A window model
// predicts outputs: a channel's level flips at an edge when the last D
// synchronised samples all differ from the current level.
module tb_input_conditioner_8;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] raw = 8'h00;
  logic [7:0] stable, rise, fall;

  int checks = 0;
  int failures = 0;

  input_conditioner_8 #(
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .raw(raw),
    .stable(stable),
    .rise(rise),
    .fall(fall)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [7:0] rq[$];   // raw sampled at the last two edges (oldest first)
  logic [7:0] evq[$];  // samples evaluated against the level at the last D edges
  logic [7:0] m_stable, m_rise, m_fall;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    rq.push_back(8'h00);
    rq.push_back(8'h00);
    evq.delete();
    for (int j = 0; j < D; j++) evq.push_back(8'h00);
    m_stable = 8'h00;
    m_rise   = 8'h00;
    m_fall   = 8'h00;
  endtask

  task automatic model_edge();
    logic [7:0] ev, flip;
    ev = rq[0];                 // raw from two edges ago reaches the decision
    rq.pop_front();
    rq.push_back(raw);
    evq.pop_front();
    evq.push_back(ev);
    flip = 8'hFF;
    foreach (evq[j]) flip &= evq[j] ^ m_stable;
    m_rise   = flip & ~m_stable;
    m_fall   = flip & m_stable;
    m_stable = m_stable ^ flip;
  endtask

  task automatic check_model();
    chk("stable_model", stable, m_stable);
    chk("rise_model", rise, m_rise);
    chk("fall_model", fall, m_fall);
  endtask

  // One clock edge: update the model, then sample the DUT 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  // Assert reset mid-cycle, hold for n edges, release mid-cycle.
  task automatic do_reset(input int n);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("reset_async_stable", stable, 8'h00);
    chk("reset_async_rise", rise, 8'h00);
    chk("reset_async_fall", fall, 8'h00);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      chk("reset_hold_stable", stable, 8'h00);
      chk("reset_hold_pulses", rise | fall, 8'h00);
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic settle_zero();
    raw = 8'h00;
    for (int j = 0; j < 10; j++) step();
  endtask

  initial begin
    int n;
    logic [7:0] mask;

    // Reset values: raw all ones during reset, level accepted at edge 5.
    raw = 8'hFF;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("por_stable", stable, 8'h00);
    chk("por_rise", rise, 8'h00);
    chk("por_fall", fall, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    n = 0;
    for (int j = 0; j < 8; j++) begin
      step();
      if (rise != 8'h00) n++;
      if (j == 4) chk("por_e4_stable", stable, 8'h00);
      if (j == 5) begin
        chk("por_e5_stable", stable, 8'hFF);
        chk("por_e5_rise", rise, 8'hFF);
      end
      if (j == 6) chk("por_e6_rise", rise, 8'h00);
    end
    chk_int("por_rise_count", n, 1);

    // Clean press and release on channel 3.
    settle_zero();
    raw = 8'h08;
    for (int j = 0; j < 10; j++) begin
      step();
      if (j == 4) chk("press_e4_stable", stable, 8'h00);
      if (j == 5) begin
        chk("press_e5_stable", stable, 8'h08);
        chk("press_e5_rise", rise, 8'h08);
      end
    end
    raw = 8'h00;
    for (int j = 0; j < 10; j++) begin
      step();
      if (j == 5) begin
        chk("release_e5_stable", stable, 8'h00);
        chk("release_e5_fall", fall, 8'h08);
      end
    end

    // Glitch rejection on channel 0: 3 high, 1 low, 3 high.
    n = 0;
    raw = 8'h01;
    for (int j = 0; j < 3; j++) begin step(); if (rise[0]) n++; end
    raw = 8'h00;
    step(); if (rise[0]) n++;
    raw = 8'h01;
    for (int j = 0; j < 3; j++) begin step(); if (rise[0]) n++; end
    raw = 8'h00;
    for (int j = 0; j < 8; j++) begin step(); if (rise[0] || stable[0]) n++; end
    chk_int("glitch_activity", n, 0);
    chk("glitch_stable", stable, 8'h00);

    // Bounce then settle on channel 5.
    n = 0;
    for (int t = 0; t < 10; t++) begin
      raw = (t % 2 == 0) ? 8'h20 : 8'h00;
      step();
      if (rise[5]) n++;
    end
    chk_int("bounce_no_rise", n, 0);
    raw = 8'h20;
    n = 0;
    for (int j = 0; j < 10; j++) begin
      step();
      if (rise[5]) n++;
      if (j == 4) chk("bounce_e4_stable", stable, 8'h00);
      if (j == 5) chk("bounce_e5_rise", rise, 8'h20);
    end
    chk_int("bounce_rise_count", n, 1);
    chk("bounce_final_stable", stable, 8'h20);

    // Simultaneous channels from all zero.
    settle_zero();
    raw = 8'hA5;
    n = 0;
    for (int j = 0; j < 10; j++) begin
      step();
      if (rise != 8'h00) n++;
      chk("simul_fall", fall, 8'h00);
      if (j == 5) begin
        chk("simul_e5_rise", rise, 8'hA5);
        chk("simul_e5_stable", stable, 8'hA5);
      end
    end
    chk_int("simul_rise_count", n, 1);

    // Asynchronous reset clears a held level without a clock edge.
    raw = 8'h00;
    do_reset(1);
    settle_zero();

    // Reset mid-count on channel 7 (counter at 2 after the fourth edge).
    raw = 8'h80;
    for (int j = 0; j < 4; j++) step();
    do_reset(1);
    n = 0;
    for (int j = 0; j < 8; j++) begin
      step();
      if (rise[7]) n++;
      if (j == 5) chk("midrst_e5_rise", rise, 8'h80);
    end
    chk_int("midrst_rise_count", n, 1);

    // Random toggling checked edge by edge against the model.
    for (int j = 0; j < 400; j++) begin
      mask = 8'h00;
      for (int b = 0; b < 8; b++)
        if ($urandom_range(4) == 0) mask[b] = 1'b1;
      raw = raw ^ mask;
      step();
      checks++;
      assert ((rise & fall) === 8'h00) else begin
        failures++;
        $error("FAIL pulse_exclusive observed=%h expected=%h", rise & fall, 8'h00);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
